semaforo_monitor: RTL and testbench

- Independent safety monitor that reads back the lamp drive signals produced by semaforo_cruzamento_otimizado, i.e. the receiving end of the lamp interface.
- Checks per-head lamp validity, cross-direction conflicts, the vehicle colour sequence, minimum yellow time and pedestrian/vehicle conflicts.
- Latches the first fault and raises safe_mode so top can force flashing yellow.
- Same clock domain as the controller (clk = filtered clock).

---
 rtl/semaforo_pkg.sv | 40 ++++
 rtl/semaforo_monitor_head.sv | 104 ++++++++++
 rtl/semaforo_monitor.sv | 141 ++++++++++++++
 tb/tb_semaforo_monitor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared definitions for the crossing controller and its safety monitor:
// head state encoding, fault codes and default timing limits.
package semaforo_pkg;

  // Tracked state of one vehicle head, as seen on its lamp outputs
  typedef enum logic [1:0] {
    HS_UNKNOWN = 2'd0,
    HS_RED     = 2'd1,
    HS_GREEN   = 2'd2,
    HS_YELLOW  = 2'd3
  } head_state_t;

  // Fault codes; a lower value has higher priority when several coincide
  localparam logic [3:0] FLT_NONE       = 4'd0;
  localparam logic [3:0] FLT_VEH_CONF   = 4'd1;
  localparam logic [3:0] FLT_PAT_A      = 4'd2;
  localparam logic [3:0] FLT_PAT_B      = 4'd3;
  localparam logic [3:0] FLT_PED_PAT_A  = 4'd4;
  localparam logic [3:0] FLT_PED_PAT_B  = 4'd5;
  localparam logic [3:0] FLT_SEQ_A      = 4'd6;
  localparam logic [3:0] FLT_SEQ_B      = 4'd7;
  localparam logic [3:0] FLT_SHORT_Y_A  = 4'd8;
  localparam logic [3:0] FLT_SHORT_Y_B  = 4'd9;
  localparam logic [3:0] FLT_PED_CONF_A = 4'd10;
  localparam logic [3:0] FLT_PED_CONF_B = 4'd11;

  // Default timing limits, shared with the controller bench
  localparam int DEF_MIN_YELLOW = 3;
  localparam int DEF_GLITCH_CYC = 2;
  localparam int DEF_CW         = 4;

  // Only the normal colour rotation is a legal change of state
  function automatic logic legal_step(input head_state_t from_st,
                                      input head_state_t to_st);
    return ((from_st == HS_RED)    && (to_st == HS_GREEN))  ||
           ((from_st == HS_GREEN)  && (to_st == HS_YELLOW)) ||
           ((from_st == HS_YELLOW) && (to_st == HS_RED));
  endfunction

endpackage

// File: rtl/semaforo_monitor_head.sv
// Tracker for one vehicle head: follows the lamp pattern, counts invalid
// patterns and yellow duration, and pulses the per-head error flags.
module monitor_head
  import semaforo_pkg::*;
#(
  parameter int MIN_YELLOW = DEF_MIN_YELLOW,
  parameter int GLITCH_CYC = DEF_GLITCH_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  output logic [1:0] state,
  output logic       seq_err,
  output logic       pat_err,
  output logic       short_yellow
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW:0]   GLITCH_LIM = (CW+1)'(GLITCH_CYC);
  localparam logic [CW:0]   YEL_LIM    = (CW+1)'(MIN_YELLOW);

  head_state_t   state_reg, state_next;
  head_state_t   pat_state;
  logic [CW-1:0] glitch_reg, glitch_next;
  logic [CW-1:0] ytimer_reg, ytimer_next;
  logic [CW:0]   glitch_inc;
  logic [CW:0]   yel_lit;
  logic [2:0]    lamps;
  logic          valid;

  assign lamps      = {green, yellow, red};
  assign glitch_inc = {1'b0, glitch_reg} + 1'b1;
  // Yellow cycles including the one in which the change to red is seen
  assign yel_lit    = {1'b0, ytimer_reg} + 1'b1;
  assign state      = state_reg;

  // Decode the lamp pattern; exactly one lit lamp is a valid pattern
  always_comb begin
    pat_state = HS_UNKNOWN;
    valid     = 1'b1;
    case (lamps)
      3'b100:  pat_state = HS_GREEN;
      3'b010:  pat_state = HS_YELLOW;
      3'b001:  pat_state = HS_RED;
      default: valid = 1'b0;
    endcase
  end

  // Next state, counters and error pulses
  always_comb begin
    state_next   = state_reg;
    glitch_next  = glitch_reg;
    ytimer_next  = ytimer_reg;
    seq_err      = 1'b0;
    pat_err      = 1'b0;
    short_yellow = 1'b0;
    if (en) begin
      if (valid) begin
        glitch_next = '0;
        state_next  = pat_state;
        // From UNKNOWN the first valid pattern is taken without judgement
        if ((state_reg != HS_UNKNOWN) && (pat_state != state_reg)) begin
          if (!legal_step(state_reg, pat_state))
            seq_err = 1'b1;
          if ((state_reg == HS_YELLOW) && (pat_state == HS_RED) &&
              (yel_lit < YEL_LIM))
            short_yellow = 1'b1;
        end
      end else begin
        if (glitch_reg != CNT_MAX)
          glitch_next = glitch_reg + 1'b1;
        if (glitch_inc >= GLITCH_LIM)
          pat_err = 1'b1;
      end
      // Yellow timer restarts on entry and counts while the head stays yellow
      if (state_next == HS_YELLOW) begin
        if (state_reg != HS_YELLOW)
          ytimer_next = '0;
        else if (ytimer_reg != CNT_MAX)
          ytimer_next = ytimer_reg + 1'b1;
      end else begin
        ytimer_next = '0;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= HS_UNKNOWN;
      glitch_reg <= '0;
      ytimer_reg <= '0;
    end else begin
      state_reg  <= state_next;
      glitch_reg <= glitch_next;
      ytimer_reg <= ytimer_next;
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Safety monitor on the lamp drive of the crossing controller: registers the
// lamps, tracks both vehicle heads, runs the cross-head checks and latches
// the first fault, which also raises safe_mode.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int MIN_YELLOW = DEF_MIN_YELLOW,
  parameter int GLITCH_CYC = DEF_GLITCH_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       light_A_GREEN,
  input  logic       light_A_YELLOW,
  input  logic       light_A_RED,
  input  logic       light_B_GREEN,
  input  logic       light_B_YELLOW,
  input  logic       light_B_RED,
  input  logic       p_light_A_GREEN,
  input  logic       p_light_A_RED,
  input  logic       p_light_B_GREEN,
  input  logic       p_light_B_RED,
  input  logic       clear_fault,
  output logic       fault,
  output logic [3:0] fault_code,
  output logic       safe_mode,
  output logic [1:0] head_state_A,
  output logic [1:0] head_state_B
);

  // Registered lamp copies; index 0 is head A, index 1 is head B.
  // Vehicle lamps are {green, yellow, red}, pedestrian lamps {green, red}.
  logic [2:0] veh_reg [2];
  logic [1:0] ped_reg [2];
  // Low until the first real sample after reset, so the zeroed copies are
  // never judged as lamp faults
  logic       in_vld_reg;

  logic [1:0] head_st [2];
  logic [1:0] seq_err;
  logic [1:0] pat_err;
  logic [1:0] short_yel;
  logic [1:0] ped_pat_err;
  logic [1:0] ped_conf;
  logic       veh_conf;
  logic [3:0] viol_code;

  logic       fault_reg;
  logic [3:0] fault_code_reg;
  logic       safe_mode_reg;

  // Sample every lamp once on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      veh_reg[0] <= '0;
      veh_reg[1] <= '0;
      ped_reg[0] <= '0;
      ped_reg[1] <= '0;
      in_vld_reg <= 1'b0;
    end else begin
      veh_reg[0] <= {light_A_GREEN, light_A_YELLOW, light_A_RED};
      veh_reg[1] <= {light_B_GREEN, light_B_YELLOW, light_B_RED};
      ped_reg[0] <= {p_light_A_GREEN, p_light_A_RED};
      ped_reg[1] <= {p_light_B_GREEN, p_light_B_RED};
      in_vld_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_head
      monitor_head #(
        .MIN_YELLOW (MIN_YELLOW),
        .GLITCH_CYC (GLITCH_CYC),
        .CW         (CW)
      ) u_head (
        .clk          (clk),
        .reset        (reset),
        .en           (in_vld_reg),
        .green        (veh_reg[gi][2]),
        .yellow       (veh_reg[gi][1]),
        .red          (veh_reg[gi][0]),
        .state        (head_st[gi]),
        .seq_err      (seq_err[gi]),
        .pat_err      (pat_err[gi]),
        .short_yellow (short_yel[gi])
      );

      // Pedestrian head must show exactly one lamp; green only over red-only traffic
      assign ped_pat_err[gi] = in_vld_reg && !(ped_reg[gi][1] ^ ped_reg[gi][0]);
      assign ped_conf[gi]    = in_vld_reg && ped_reg[gi][1] &&
                               (veh_reg[gi] != 3'b001);
    end
  endgenerate

  // Both directions showing green or yellow at once
  assign veh_conf = in_vld_reg && (veh_reg[0][2] || veh_reg[0][1]) &&
                    (veh_reg[1][2] || veh_reg[1][1]);

  // Priority encode this cycle's violations, lowest code first
  always_comb begin
    viol_code = FLT_NONE;
    if (veh_conf)            viol_code = FLT_VEH_CONF;
    else if (pat_err[0])     viol_code = FLT_PAT_A;
    else if (pat_err[1])     viol_code = FLT_PAT_B;
    else if (ped_pat_err[0]) viol_code = FLT_PED_PAT_A;
    else if (ped_pat_err[1]) viol_code = FLT_PED_PAT_B;
    else if (seq_err[0])     viol_code = FLT_SEQ_A;
    else if (seq_err[1])     viol_code = FLT_SEQ_B;
    else if (short_yel[0])   viol_code = FLT_SHORT_Y_A;
    else if (short_yel[1])   viol_code = FLT_SHORT_Y_B;
    else if (ped_conf[0])    viol_code = FLT_PED_CONF_A;
    else if (ped_conf[1])    viol_code = FLT_PED_CONF_B;
  end

  // Fault latch: keep the first code; a clear request only succeeds in a
  // clean cycle, otherwise the violation seen alongside it is latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_reg      <= 1'b0;
      fault_code_reg <= FLT_NONE;
      safe_mode_reg  <= 1'b0;
    end else if (viol_code != FLT_NONE) begin
      if (!fault_reg || clear_fault) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= viol_code;
        safe_mode_reg  <= 1'b1;
      end
    end else if (clear_fault) begin
      fault_reg      <= 1'b0;
      fault_code_reg <= FLT_NONE;
      safe_mode_reg  <= 1'b0;
    end
  end

  assign fault        = fault_reg;
  assign fault_code   = fault_code_reg;
  assign safe_mode    = safe_mode_reg;
  assign head_state_A = head_st[0];
  assign head_state_B = head_st[1];

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: drives lamp patterns and compares the
// monitor outputs with hand-computed values.
module tb_semaforo_monitor;

  localparam logic [2:0] V_GRN = 3'b100;
  localparam logic [2:0] V_YEL = 3'b010;
  localparam logic [2:0] V_RED = 3'b001;
  localparam logic [2:0] V_OFF = 3'b000;
  localparam logic [1:0] P_RED = 2'b01;
  localparam logic [1:0] P_BAD = 2'b11;

  logic       clk;
  logic       reset;
  logic [2:0] a_l;
  logic [2:0] b_l;
  logic [1:0] pa_l;
  logic [1:0] pb_l;
  logic       clear_fault;
  logic       fault;
  logic [3:0] fault_code;
  logic       safe_mode;
  logic [1:0] head_state_A;
  logic [1:0] head_state_B;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  semaforo_monitor dut (
    .clk             (clk),
    .reset           (reset),
    .light_A_GREEN   (a_l[2]),
    .light_A_YELLOW  (a_l[1]),
    .light_A_RED     (a_l[0]),
    .light_B_GREEN   (b_l[2]),
    .light_B_YELLOW  (b_l[1]),
    .light_B_RED     (b_l[0]),
    .p_light_A_GREEN (pa_l[1]),
    .p_light_A_RED   (pa_l[0]),
    .p_light_B_GREEN (pb_l[1]),
    .p_light_B_RED   (pb_l[0]),
    .clear_fault     (clear_fault),
    .fault           (fault),
    .fault_code      (fault_code),
    .safe_mode       (safe_mode),
    .head_state_A    (head_state_A),
    .head_state_B    (head_state_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Reset held across one edge, released 1 unit after it
  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    clear_fault = 1'b0;
    a_l  = V_RED;
    b_l  = V_RED;
    pa_l = P_RED;
    pb_l = P_RED;
    tick(2);
    check_val("rst_fault", 8'(fault), 8'd0);
    check_val("rst_code", 8'(fault_code), 8'd0);
    check_val("rst_safe", 8'(safe_mode), 8'd0);
    check_val("rst_hsA", 8'(head_state_A), 8'd0);
    check_val("rst_hsB", 8'(head_state_B), 8'd0);
    reset = 1'b0;
    tick(2);
    check_val("init_hsA_red", 8'(head_state_A), 8'd1);
    check_val("init_hsB_red", 8'(head_state_B), 8'd1);

    // Legal A rotation: green 5, yellow 3, then red
    a_l = V_GRN; tick(2);
    check_val("legal_hsA_grn", 8'(head_state_A), 8'd2);
    tick(3);
    a_l = V_YEL; tick(2);
    check_val("legal_hsA_yel", 8'(head_state_A), 8'd3);
    tick(1);
    a_l = V_RED; tick(2);
    check_val("legal_hsA_red", 8'(head_state_A), 8'd1);
    check_val("legal_fault", 8'(fault), 8'd0);
    check_val("legal_hsB", 8'(head_state_B), 8'd1);

    // Vehicle conflict: A green with B yellow
    a_l = V_GRN; b_l = V_YEL; tick(1);
    check_val("conf_not_yet", 8'(fault), 8'd0);
    tick(1);
    check_val("conf_fault", 8'(fault), 8'd1);
    check_val("conf_code", 8'(fault_code), 8'd1);
    check_val("conf_safe", 8'(safe_mode), 8'd1);

    // Short yellow on A (2 cycles), then a later conflict keeps code 8
    a_l = V_RED; b_l = V_RED;
    pulse_reset();
    tick(2);
    check_val("sy_clean", 8'(fault), 8'd0);
    a_l = V_GRN; tick(3);
    a_l = V_YEL; tick(2);
    a_l = V_RED; tick(2);
    check_val("sy_fault", 8'(fault), 8'd1);
    check_val("sy_code", 8'(fault_code), 8'd8);
    a_l = V_GRN; b_l = V_GRN; tick(2);
    check_val("sy_code_kept", 8'(fault_code), 8'd8);

    // Glitch tolerance: one dark cycle is fine, two is a pattern fault
    a_l = V_RED; b_l = V_RED;
    pulse_reset();
    tick(2);
    a_l = V_OFF; tick(1);
    a_l = V_RED; tick(2);
    check_val("glitch1_fault", 8'(fault), 8'd0);
    a_l = V_OFF; tick(2);
    a_l = V_RED; tick(1);
    check_val("glitch2_fault", 8'(fault), 8'd1);
    check_val("glitch2_code", 8'(fault_code), 8'd2);
    clear_fault = 1'b1; tick(1);
    clear_fault = 1'b0;
    check_val("clr_fault", 8'(fault), 8'd0);
    check_val("clr_code", 8'(fault_code), 8'd0);
    check_val("clr_safe", 8'(safe_mode), 8'd0);
    tick(2);
    check_val("clr_stays", 8'(fault), 8'd0);

    // Priority: pedestrian B pattern (5) beats A sequence error (6)
    a_l = V_GRN; b_l = V_RED;
    pulse_reset();
    tick(2);
    check_val("prio_clean", 8'(fault), 8'd0);
    check_val("prio_hsA_grn", 8'(head_state_A), 8'd2);
    a_l = V_RED; pb_l = P_BAD; tick(2);
    check_val("prio_code", 8'(fault_code), 8'd5);
    pb_l = P_RED;

    // Reset mid-yellow, then re-init from UNKNOWN and a red->yellow error
    a_l = V_RED; b_l = V_RED;
    pulse_reset();
    tick(2);
    a_l = V_GRN; tick(3);
    a_l = V_YEL; tick(2);
    check_val("mid_hsA_yel", 8'(head_state_A), 8'd3);
    reset = 1'b1; #1;
    check_val("mid_rst_fault", 8'(fault), 8'd0);
    check_val("mid_rst_code", 8'(fault_code), 8'd0);
    check_val("mid_rst_safe", 8'(safe_mode), 8'd0);
    check_val("mid_rst_hsA", 8'(head_state_A), 8'd0);
    check_val("mid_rst_hsB", 8'(head_state_B), 8'd0);
    a_l = V_RED; tick(1);
    reset = 1'b0;
    tick(2);
    check_val("reinit_hsA", 8'(head_state_A), 8'd1);
    check_val("reinit_fault", 8'(fault), 8'd0);
    a_l = V_YEL; tick(2);
    check_val("seq_code", 8'(fault_code), 8'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
